// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - fetch unit bundle: memory port, redirect, decode handshake
//
// master: ifu_fetch side (drives ifu_rd_req/ifu_rd_addr and the if_* head outputs)
// slave : environment side (memory, execute redirect, decode ready)
//   ifu_rd_req, ifu_rd_addr, ifu_rd_data  instruction memory read port
//   redirect_valid, redirect_addr         taken-jump redirect pulse from execute
//   if_valid, if_instr, if_pc, if_opcode  queue head presented to decode
//   id_ready                              decode accepts head when if_valid && id_ready
`timescale 1ns/1ps
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

interface ifu_fetch_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [2:0]            if_opcode;
  logic                  id_ready;

  modport master (
    output ifu_rd_req, ifu_rd_addr, if_valid, if_instr, if_pc, if_opcode,
    input  ifu_rd_data, redirect_valid, redirect_addr, id_ready
  );

  modport slave (
    input  ifu_rd_req, ifu_rd_addr, if_valid, if_instr, if_pc, if_opcode,
    output ifu_rd_data, redirect_valid, redirect_addr, id_ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch front end: PC, one read per cycle, 2-entry queue
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    ifu_fetch_if.master: memory read port, redirect input, decode handshake
`timescale 1ns/1ps
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module ifu_fetch #(
  parameter int                    ADDR_WIDTH = `ADDR_WIDTH,
  parameter int                    DATA_WIDTH = `DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = 'o200
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master bus
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [1:0]            r_count;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;
  // Entry 0 is always the head; entry 1 only meaningful when r_count == 2.
  logic [DATA_WIDTH-1:0] r_instr0;
  logic [DATA_WIDTH-1:0] r_instr1;
  logic [ADDR_WIDTH-1:0] r_epc0;
  logic [ADDR_WIDTH-1:0] r_epc1;

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [2:0]            w_occ;
  logic [DATA_WIDTH-1:0] w_instr;

  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid && bus.id_ready;
  assign w_push  = r_inflight && !bus.redirect_valid;

  // Credit: buffered words plus the outstanding read, minus what decode
  // takes this cycle, must leave room for the word a new request returns.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = rst_n && !bus.redirect_valid && (w_occ < 3'd2);

  assign w_instr = w_valid ? r_instr0 : '0;

  assign bus.ifu_rd_req  = w_issue;
  assign bus.ifu_rd_addr = r_pc;
  assign bus.if_valid    = w_valid;
  assign bus.if_instr    = w_instr;
  assign bus.if_pc       = w_valid ? r_epc0 : '0;
  assign bus.if_opcode   = w_instr[DATA_WIDTH-1 -: 3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= START_ADDR;
      r_count       <= 2'd0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_instr0      <= '0;
      r_instr1      <= '0;
      r_epc0        <= '0;
      r_epc1        <= '0;
    end else if (bus.redirect_valid) begin
      // Flush: the returning word is dropped by clearing r_inflight.
      r_pc       <= bus.redirect_addr;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      if (w_issue) begin
        r_pc          <= r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        r_inflight_pc <= r_pc;
      end
      r_inflight <= w_issue;

      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_instr0 <= bus.ifu_rd_data;
            r_epc0   <= r_inflight_pc;
          end else begin
            r_instr1 <= bus.ifu_rd_data;
            r_epc1   <= r_inflight_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_instr0 <= r_instr1;
          r_epc0   <= r_epc1;
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop: shift and append so order is kept.
          if (r_count == 2'd1) begin
            r_instr0 <= bus.ifu_rd_data;
            r_epc0   <= r_inflight_pc;
          end else begin
            r_instr0 <= r_instr1;
            r_epc0   <= r_epc1;
            r_instr1 <= bus.ifu_rd_data;
            r_epc1   <= r_inflight_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch with randomized ready/redirect/reset
`timescale 1ns/1ps

module tb_ifu_fetch;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam logic [AW-1:0] START = 12'o0200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ifu_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ifu_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(START)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   delivered = 0;

  // Memory contents: a fixed scramble of the address so every word differs.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = (a * 12'd37) ^ 12'o5252 ^ {a[5:0], a[11:6]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Memory responder: answers each request one cycle later, garbage while in reset;
  // every answered request becomes an expected decode-side word.
  initial begin : memory
    logic          c_req;
    logic [AW-1:0] c_addr;
    logic          c_rst;
    exp_t          e;
    bus.ifu_rd_data = '0;
    forever begin
      @(negedge clk);
      c_req  = bus.ifu_rd_req;
      c_addr = bus.ifu_rd_addr;
      c_rst  = rst_n;
      @(posedge clk);
      #1;
      if (!c_rst) begin
        bus.ifu_rd_data = DW'($urandom);
      end else if (c_req) begin
        bus.ifu_rd_data = mem_word(c_addr);
        e.pc    = c_addr;
        e.instr = mem_word(c_addr);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: consumes handshakes against the expected queue, checks the
  // outstanding-word bound, request addresses, fill latency and stall stability.
  initial begin : monitor
    int            since;
    int            low_run;
    logic          prev_stall;
    logic [AW-1:0] s_pc;
    logic [DW-1:0] s_instr;
    logic [AW-1:0] exp_req_addr;
    logic          want_req;
    exp_t          e;
    since = 100;
    low_run = 0;
    prev_stall = 1'b0;
    s_pc = '0;
    s_instr = '0;
    exp_req_addr = START;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_run++;
        chk("req_in_reset", 32'(bus.ifu_rd_req), 32'd0);
        if (low_run >= 2) begin
          chk("rst_valid", 32'(bus.if_valid), 32'd0);
          chk("rst_instr", 32'(bus.if_instr), 32'd0);
          chk("rst_pc", 32'(bus.if_pc), 32'd0);
          chk("rst_opcode", 32'(bus.if_opcode), 32'd0);
          chk("rst_addr", 32'(bus.ifu_rd_addr), 32'(START));
        end
        exp_q.delete();
        exp_req_addr = START;
        since = -1;
        prev_stall = 1'b0;
      end else begin
        low_run = 0;
        if (since < 100) since++;
        if (prev_stall) begin
          chk("stall_valid", 32'(bus.if_valid), 32'd1);
          chk("stall_pc", 32'(bus.if_pc), 32'(s_pc));
          chk("stall_instr", 32'(bus.if_instr), 32'(s_instr));
        end
        if (since == 0 || since == 1) chk("valid_during_fill", 32'(bus.if_valid), 32'd0);
        if (since == 2) chk("valid_latency", 32'(bus.if_valid), 32'd1);
        if (bus.if_valid && bus.id_ready) begin
          if (exp_q.size() == 0) begin
            chk("pop_unexpected_qsize", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("pop_pc", 32'(bus.if_pc), 32'(e.pc));
            chk("pop_instr", 32'(bus.if_instr), 32'(e.instr));
            chk("pop_opcode", 32'(bus.if_opcode), 32'(e.instr[DW-1 -: 3]));
            delivered++;
          end
        end
        want_req = !bus.redirect_valid && (exp_q.size() < 2);
        chk("req_credit", 32'(bus.ifu_rd_req), 32'(want_req));
        if (bus.ifu_rd_req) begin
          chk("req_addr", 32'(bus.ifu_rd_addr), 32'(exp_req_addr));
          exp_req_addr = exp_req_addr + 12'd1;
        end
        prev_stall = bus.if_valid && !bus.id_ready && !bus.redirect_valid;
        s_pc = bus.if_pc;
        s_instr = bus.if_instr;
        if (bus.redirect_valid) begin
          exp_q.delete();
          exp_req_addr = bus.redirect_addr;
          since = -1;
        end
      end
    end
  end

  task automatic hold(input int n, input logic r, input logic rdy);
    rst_n = r;
    bus.id_ready = rdy;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [AW-1:0] a);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr = a;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
  endtask

  initial begin : stimulus
    rst_n = 1'b0;
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    hold(20, 1'b1, 1'b1);          // startup streaming
    hold(2, 1'b0, 1'b0);
    hold(8, 1'b1, 1'b0);           // backpressure from cycle 0
    hold(10, 1'b1, 1'b1);
    hold(3, 1'b1, 1'b0);           // fill, then flush while stalled
    redirect(12'o4000);
    hold(10, 1'b1, 1'b1);
    redirect(12'o1234);            // redirect coinciding with a pop
    hold(8, 1'b1, 1'b1);
    redirect(12'o7776);            // pc wrap
    hold(10, 1'b1, 1'b1);
    hold(1, 1'b1, 1'b0);           // reset with a word buffered and one in flight
    hold(1, 1'b0, 1'b1);
    hold(10, 1'b1, 1'b1);
    hold(3, 1'b1, 1'b0);           // reset with queue full
    hold(1, 1'b0, 1'b0);
    hold(6, 1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      bus.id_ready = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      bus.redirect_valid = ($urandom_range(0, 24) == 0);
      bus.redirect_addr = ($urandom_range(0, 3) == 0) ? AW'(12'o7775 + AW'($urandom_range(0, 3)))
                                                      : AW'($urandom);
      @(posedge clk);
      #1;
    end
    bus.redirect_valid = 1'b0;
    hold(6, 1'b1, 1'b1);
    chk("delivered_enough", 32'(delivered > 500), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
